debug_req_controller: RTL and testbench

//  Debug-module-side initiator for the core debug interface: drives debug_req to the core and

---
 rtl/debug_req_pkg.sv | 13 +
 rtl/debug_req_timer.sv | 32 +++
 rtl/debug_req_controller.sv | 127 ++++++++++++
 tb/tb_debug_req_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_req_pkg.sv
// Shared types and default parameters for the debug request controller.
package debug_req_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_REQ    = 2'd1,
    DBG_HALTED = 2'd2
  } dbg_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/debug_req_timer.sv
// Request timer: counts cycles while enabled, flags the last allowed cycle.
// A limit of 0 disables expiry entirely.
module debug_req_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // Cycle counter; clear has priority so every request starts from 0.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // Expiry marks the final cycle the request may stay up (count == limit-1).
  always_comb begin
    expired = (limit != '0) && (count == (limit - W'(1)));
  end

endmodule

// File: rtl/debug_req_controller.sv
// Debug request initiator: converts a host halt pulse into a held debug_req
// level, waits for the core to halt (or times out), then tracks resume.
// Optional feature macro: DEBUG_AUTO_HALT_EN (halt-on-reset: a havereset
// rise seen while idle starts a halt request on its own).
import debug_req_pkg::*;

module debug_req_controller #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             halt_req_i,
  input  logic             havereset_clr_i,
  input  logic             debug_havereset_i,
  input  logic             debug_running_i,
  input  logic             debug_halted_i,
  output logic             debug_req_o,
  output logic             busy_o,
  output logic             halt_ack_o,
  output logic             timeout_o,
  output logic             resume_done_o,
  output logic             havereset_seen_o,
  output logic [CNT_W-1:0] halt_count_o
);

  localparam int TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  dbg_state_e state;
  logic       havereset_prev;
  logic       havereset_rise;
  logic       start;
  logic       tmr_expired;
  logic       in_req;

  assign in_req         = (state == DBG_REQ);
  assign havereset_rise = debug_havereset_i & ~havereset_prev;

`ifdef DEBUG_AUTO_HALT_EN
  assign start = halt_req_i | havereset_rise;
`else
  assign start = halt_req_i;
`endif

  // Timer runs only in REQ and is held at 0 otherwise, so each entry starts fresh.
  debug_req_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .clear   (~in_req),
    .enable  (in_req),
    .limit   (TMR_LIMIT),
    .expired (tmr_expired)
  );

  // Havereset edge detect and sticky flag; a new rise beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      havereset_prev   <= 1'b0;
      havereset_seen_o <= 1'b0;
    end else begin
      havereset_prev <= debug_havereset_i;
      if (havereset_rise) begin
        havereset_seen_o <= 1'b1;
      end else if (havereset_clr_i) begin
        havereset_seen_o <= 1'b0;
      end
    end
  end

  // Request FSM with registered outputs; status pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= DBG_IDLE;
      debug_req_o   <= 1'b0;
      busy_o        <= 1'b0;
      halt_ack_o    <= 1'b0;
      timeout_o     <= 1'b0;
      resume_done_o <= 1'b0;
      halt_count_o  <= '0;
    end else begin
      halt_ack_o    <= 1'b0;
      timeout_o     <= 1'b0;
      resume_done_o <= 1'b0;
      case (state)
        DBG_IDLE: begin
          if (start) begin
            state       <= DBG_REQ;
            debug_req_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        DBG_REQ: begin
          // Halted is checked first so it wins over a coincident timeout.
          if (debug_halted_i) begin
            state       <= DBG_HALTED;
            debug_req_o <= 1'b0;
            halt_ack_o  <= 1'b1;
            if (halt_count_o != {CNT_W{1'b1}}) begin
              halt_count_o <= halt_count_o + CNT_W'(1);
            end
          end else if (tmr_expired) begin
            state       <= DBG_IDLE;
            debug_req_o <= 1'b0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b1;
          end
        end
        DBG_HALTED: begin
          if (debug_running_i) begin
            state         <= DBG_IDLE;
            busy_o        <= 1'b0;
            resume_done_o <= 1'b1;
          end
        end
        default: begin
          state       <= DBG_IDLE;
          debug_req_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_req_controller.sv
// Directed bench for debug_req_controller (TIMEOUT_CYCLES=16, CNT_W=2).
module tb_debug_req_controller;

  logic       clk;
  logic       rst_ni;
  logic       halt_req;
  logic       hr_clr;
  logic       havereset;
  logic       running;
  logic       halted;
  logic       debug_req_o;
  logic       busy_o;
  logic       halt_ack_o;
  logic       timeout_o;
  logic       resume_done_o;
  logic       havereset_seen_o;
  logic [1:0] halt_count_o;

  int n_tests;
  int n_fail;
  int rc, ac, tc;

  debug_req_controller #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (2)
  ) dut (
    .clk               (clk),
    .rst_ni            (rst_ni),
    .halt_req_i        (halt_req),
    .havereset_clr_i   (hr_clr),
    .debug_havereset_i (havereset),
    .debug_running_i   (running),
    .debug_halted_i    (halted),
    .debug_req_o       (debug_req_o),
    .busy_o            (busy_o),
    .halt_ack_o        (halt_ack_o),
    .timeout_o         (timeout_o),
    .resume_done_o     (resume_done_o),
    .havereset_seen_o  (havereset_seen_o),
    .halt_count_o      (halt_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse halt_req, then follow the request; core raises halted once
  // debug_req has been seen high halt_at times (0 = never).
  task automatic do_halt(input int halt_at, output int req_cyc, output int acks, output int tos);
    req_cyc = 0; acks = 0; tos = 0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!debug_req_o) break;
      req_cyc++;
      if (halt_at != 0 && req_cyc == halt_at) halted = 1'b1;
      tick();
      if (halt_ack_o) acks++;
      if (timeout_o) tos++;
    end
  endtask

  task automatic resume(input string tag);
    halted  = 1'b0;
    running = 1'b1;
    tick();
    check({tag, "_resume_done"}, resume_done_o, 1);
    check({tag, "_busy_after_resume"}, busy_o, 0);
    running = 1'b0;
    tick();
    check({tag, "_resume_done_pulse"}, resume_done_o, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_ni = 1'b0; halt_req = 1'b0; hr_clr = 1'b0;
    havereset = 1'b0; running = 1'b0; halted = 1'b0;
    tick(); tick();
    check("rst_req", debug_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_count", halt_count_o, 0);
    check("rst_seen", havereset_seen_o, 0);
    check("rst_pulses", {halt_ack_o, timeout_o, resume_done_o}, 0);
    rst_ni = 1'b1;
    tick();

    // 1: halted arrives after 5 request cycles
    do_halt(5, rc, ac, tc);
    check("t1_req_cycles", rc, 5);
    check("t1_acks", ac, 1);
    check("t1_timeouts", tc, 0);
    check("t1_count", halt_count_o, 1);
    check("t1_req_low_halted", debug_req_o, 0);
    check("t1_busy_halted", busy_o, 1);
    tick();
    check("t1_ack_pulse", halt_ack_o, 0);
    check("t1_still_halted", busy_o, 1);

    // 2: resume
    resume("t2");

    // 3: timeout after exactly 16 cycles, then halted on cycle 16 wins
    do_halt(0, rc, ac, tc);
    check("t3_to_req_cycles", rc, 16);
    check("t3_to_timeouts", tc, 1);
    check("t3_to_acks", ac, 0);
    check("t3_to_count", halt_count_o, 1);
    check("t3_to_busy", busy_o, 0);
    tick();
    check("t3_to_pulse", timeout_o, 0);
    do_halt(16, rc, ac, tc);
    check("t3_edge_req_cycles", rc, 16);
    check("t3_edge_acks", ac, 1);
    check("t3_edge_timeouts", tc, 0);
    check("t3_edge_count", halt_count_o, 2);
    resume("t3");

    // 4: second halt_req in REQ and in HALTED is dropped
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("t4_req_held", debug_req_o, 1);
    halted = 1'b1; tick();
    check("t4_ack", halt_ack_o, 1);
    check("t4_count", halt_count_o, 3);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("t4_no_ack_halted", halt_ack_o, 0);
    resume("t4");
    tick();
    check("t4_no_queued_req", busy_o, 0);
    check("t4_no_queued_dreq", debug_req_o, 0);
    // two more halts: count stays saturated at 3
    do_halt(2, rc, ac, tc);
    resume("t4a");
    do_halt(1, rc, ac, tc);
    check("t4_sat_acks", ac, 1);
    check("t4_sat_count", halt_count_o, 3);
    resume("t4b");

    // 5: havereset rise with simultaneous clear -> set wins
    havereset = 1'b1; hr_clr = 1'b1;
    tick();
    check("t5_seen_set", havereset_seen_o, 1);
`ifdef DEBUG_AUTO_HALT_EN
    check("t5_auto_req", debug_req_o, 1);
`else
    check("t5_no_auto_req", debug_req_o, 0);
`endif
    tick();
    hr_clr = 1'b0;
    check("t5_seen_clr", havereset_seen_o, 0);
    havereset = 1'b0;
`ifdef DEBUG_AUTO_HALT_EN
    halted = 1'b1; tick();
    resume("t5");
`endif
    tick();
    check("t5_idle", busy_o, 0);

    // 6: async reset mid-request
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick();
    check("t6_in_req", debug_req_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_async_req", debug_req_o, 0);
    check("t6_async_busy", busy_o, 0);
    check("t6_async_count", halt_count_o, 0);
    check("t6_async_pulses", {halt_ack_o, timeout_o, resume_done_o, havereset_seen_o}, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("t6_idle_after", busy_o, 0);
    // core already halted: REQ still lasts one cycle
    halted = 1'b1;
    do_halt(0, rc, ac, tc);
    check("t6_min_req", rc, 1);
    check("t6_min_ack", ac, 1);
    check("t6_count_restart", halt_count_o, 1);
    resume("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog keeps the run bounded.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
